// File: rtl/plr_elastic_pkg.sv
// Shared pipeline package: elastic stage state encoding and NOP constants.
// Imported by pipeline stages that carry instructions or generic payloads.
package plr_elastic_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } plr_state_t;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  function automatic logic [1:0] occ_of(plr_state_t s);
    unique case (s)
      ST_EMPTY: occ_of = 2'd0;
      ST_ONE:   occ_of = 2'd1;
      ST_FULL:  occ_of = 2'd2;
      default:  occ_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/plr_elastic.sv
// Two-entry elastic pipeline stage (main + skid), flushable, NOP bubbles.
// Optional macro PLR_ELASTIC_STALL_CNT_EN adds a saturating stall counter.
module plr_elastic
  import plr_elastic_pkg::*;
#(
  parameter int               WIDTH   = 16,
  parameter logic [WIDTH-1:0] NOP_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
`ifdef PLR_ELASTIC_STALL_CNT_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  plr_state_t       state;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             acc;
  logic             con;

  assign in_ready  = (state != ST_FULL);
  assign out_valid = (state != ST_EMPTY);
  assign out_data  = main_q;
  assign occupancy = occ_of(state);
  assign acc       = in_valid & in_ready;
  assign con       = out_valid & out_ready;

  // State and entry registers; main reloads NOP whenever the stage empties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_EMPTY;
      main_q <= NOP_VAL;
      skid_q <= NOP_VAL;
    end else if (flush) begin
      state  <= ST_EMPTY;
      main_q <= NOP_VAL;
      skid_q <= NOP_VAL;
    end else begin
      unique case (state)
        ST_EMPTY: begin
          if (acc) begin
            main_q <= in_data;
            state  <= ST_ONE;
          end
        end
        ST_ONE: begin
          unique case ({acc, con})
            2'b11: main_q <= in_data;
            2'b10: begin
              skid_q <= in_data;
              state  <= ST_FULL;
            end
            2'b01: begin
              main_q <= NOP_VAL;
              state  <= ST_EMPTY;
            end
            default: ;
          endcase
        end
        ST_FULL: begin
          if (con) begin
            main_q <= skid_q;
            skid_q <= NOP_VAL;
            state  <= ST_ONE;
          end
        end
        default: begin
          state  <= ST_EMPTY;
          main_q <= NOP_VAL;
          skid_q <= NOP_VAL;
        end
      endcase
    end
  end

`ifdef PLR_ELASTIC_STALL_CNT_EN
  // Count back-pressure cycles; saturates, survives flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 16'd0;
    end else if (out_valid && !out_ready && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_plr_elastic.sv
// Self-checking bench for plr_elastic against a queue-based reference.
// Directed scenarios followed by randomized traffic with flushes.
module tb_plr_elastic;

  localparam logic [15:0] NOP = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = 16'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic [1:0]  occupancy;
`ifdef PLR_ELASTIC_STALL_CNT_EN
  logic [15:0] stall_cnt;
  int          stall_model = 0;
`endif

  logic [15:0] q[$];
  int errors = 0;
  int checks = 0;

  plr_elastic #(.WIDTH(16), .NOP_VAL(16'h0000)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
`ifdef PLR_ELASTIC_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    logic [15:0] eh;
    eh = (q.size() != 0) ? q[0] : NOP;
    chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, q.size() != 0});
    chk({tag, ".data"}, {16'd0, out_data}, {16'd0, eh});
    chk({tag, ".occ"}, {30'd0, occupancy}, q.size());
    chk({tag, ".rdy"}, {31'd0, in_ready}, {31'd0, q.size() < 2});
`ifdef PLR_ELASTIC_STALL_CNT_EN
    chk({tag, ".stall"}, {16'd0, stall_cnt}, stall_model);
`endif
  endtask

  task automatic drive(bit v, logic [15:0] d, bit r, bit f);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
  endtask

  // One clock: reference update from pre-edge inputs, then sample.
  task automatic tick();
    bit acc;
    bit con;
    acc = in_valid && (q.size() < 2);
    con = (q.size() != 0) && out_ready;
`ifdef PLR_ELASTIC_STALL_CNT_EN
    if (q.size() != 0 && !out_ready && stall_model < 65535)
      stall_model++;
`endif
    @(posedge clk);
    if (flush) begin
      q.delete();
    end else begin
      if (con) void'(q.pop_front());
      if (acc) q.push_back(in_data);
    end
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst.valid", {31'd0, out_valid}, 0);
    chk("rst.data", {16'd0, out_data}, 0);
    chk("rst.occ", {30'd0, occupancy}, 0);
    chk("rst.rdy", {31'd0, in_ready}, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_all("idle");

    // Streaming at full rate
    drive(1, 16'h1001, 1, 0); tick(); check_all("s1");
    chk("s1.d", {16'd0, out_data}, 32'h1001);
    drive(1, 16'h1002, 1, 0); tick(); check_all("s2");
    chk("s2.d", {16'd0, out_data}, 32'h1002);
    drive(1, 16'h1003, 1, 0); tick(); check_all("s3");
    chk("s3.d", {16'd0, out_data}, 32'h1003);
    chk("s3.occ", {30'd0, occupancy}, 1);
    drive(0, 16'h0, 1, 0); tick(); check_all("s4");

    // Fill skid under back-pressure, then drain
    drive(1, 16'hA000, 0, 0); tick(); check_all("b1");
    drive(1, 16'hA001, 0, 0); tick(); check_all("b2");
    chk("b2.occ", {30'd0, occupancy}, 2);
    chk("b2.rdy", {31'd0, in_ready}, 0);
    chk("b2.d", {16'd0, out_data}, 32'hA000);
    drive(1, 16'hA0FF, 0, 0); tick(); check_all("b3");
    drive(0, 16'h0, 1, 0); tick(); check_all("b4");
    chk("b4.d", {16'd0, out_data}, 32'hA001);
    chk("b4.rdy", {31'd0, in_ready}, 1);
    tick(); check_all("b5");

    // Flush while full, with a concurrent offer
    drive(1, 16'hB000, 0, 0); tick();
    drive(1, 16'hB001, 0, 0); tick(); check_all("f0");
    drive(1, 16'hB002, 1, 1); tick(); check_all("f1");
    chk("f1.valid", {31'd0, out_valid}, 0);
    chk("f1.d", {16'd0, out_data}, 0);
    drive(0, 16'h0, 1, 0); tick(); check_all("f2");

    // Asynchronous reset while full
    drive(1, 16'hD000, 0, 0); tick();
    drive(1, 16'hD001, 0, 0); tick(); check_all("r0");
    #2 rst_n = 1'b0;
    #1;
    chk("ar.valid", {31'd0, out_valid}, 0);
    chk("ar.data", {16'd0, out_data}, 0);
    chk("ar.occ", {30'd0, occupancy}, 0);
    chk("ar.rdy", {31'd0, in_ready}, 1);
    q.delete();
`ifdef PLR_ELASTIC_STALL_CNT_EN
    stall_model = 0;
`endif
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 16'hC000, 1, 0); tick(); check_all("r1");
    chk("r1.d", {16'd0, out_data}, 32'hC000);
    drive(0, 16'h0, 1, 0); tick(); check_all("r2");

`ifdef PLR_ELASTIC_STALL_CNT_EN
    drive(1, 16'hE000, 0, 0); tick();
    drive(0, 16'h0, 0, 0);
    for (int i = 0; i < 5; i++) tick();
    check_all("sc");
    force dut.stall_cnt = 16'hFFFD;
    #1 release dut.stall_cnt;
    stall_model = 16'hFFFD;
    for (int i = 0; i < 5; i++) tick();
    chk("sc.sat", {16'd0, stall_cnt}, 32'hFFFF);
    drive(0, 16'h0, 1, 1); tick();
`endif

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 4) != 0, 16'($urandom),
            ($urandom % 3) != 0, ($urandom % 25) == 0);
      tick();
      check_all("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/plr_elastic.md
PLR_ELASTIC -- requirements
Module: plr_elastic

Interface
REQ-001 SHALL have parameter WIDTH, default 16: payload width in bits, >=1.
REQ-002 SHALL have parameter NOP_VAL, default {WIDTH{1'b0}}: bubble value driven on out_data when the stage is empty.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port flush, input, 1: synchronous squash of all held entries (branch taken / halt).
REQ-006 SHALL have port in_valid, input, 1: upstream presents in_data.
REQ-007 SHALL have port in_ready, output, 1: stage accepts in_data this cycle; registered.
REQ-008 SHALL have port in_data, input, WIDTH: upstream payload.
REQ-009 SHALL have port out_valid, output, 1: out_data holds a live entry.
REQ-010 SHALL have port out_ready, input, 1: downstream consumes out_data this cycle.
REQ-011 SHALL have port out_data, output, WIDTH: registered head entry, or NOP_VAL when out_valid=0.
REQ-012 SHALL have port occupancy, output, 2: entries held, 0..2.

Function
REQ-013 SHALL hold at most two entries: main register (drives out_data) and skid register.
REQ-014 SHALL implement states EMPTY (0 entries), ONE (main only), FULL (main+skid); occupancy = 0/1/2.
REQ-015 Transfers SHALL be: accept = in_valid & in_ready; consume = out_valid & out_ready.
REQ-016 EMPTY: accept -> ONE, main <= in_data; otherwise stay.
REQ-017 ONE: accept & consume -> ONE, main <= in_data; accept & ~consume -> FULL, skid <= in_data; ~accept & consume -> EMPTY; else stay.
REQ-018 FULL: in_ready=0; consume -> ONE, main <= skid; else stay, both registers held.
REQ-019 in_ready SHALL equal (state != FULL), derived from registered state only, never combinationally from out_ready.
REQ-020 Latency in_data -> out_data SHALL be exactly 1 cycle when EMPTY/ONE and out_ready=1; sustained throughput 1 entry/cycle.
REQ-021 Entry order SHALL be strictly FIFO; no entry duplicated or dropped except by flush.
REQ-022 flush SHALL take priority over all transfers: next state EMPTY, main <= NOP_VAL, in-cycle accept and consume discarded.
REQ-023 out_data SHALL equal NOP_VAL whenever out_valid=0.
REQ-024 out_valid SHALL equal (state != EMPTY).

Reset
REQ-025 rst_n low SHALL immediately force state EMPTY, out_valid=0, in_ready=1, occupancy=0, out_data=NOP_VAL, skid=NOP_VAL, independent of clk.
REQ-026 Reset mid-transfer SHALL discard all held entries; first accept after rst_n rises follows REQ-016.

Configuration
REQ-027 Macro PLR_ELASTIC_STALL_CNT_EN SHALL, when defined, add output stall_cnt, 16 bits: increments each cycle with out_valid & ~out_ready, saturates at 16'hFFFF, cleared only by reset, unaffected by flush.
REQ-028 Without PLR_ELASTIC_STALL_CNT_EN, port stall_cnt and its counter SHALL not exist; all other behaviour identical.

Structure
REQ-029 State encoding (EMPTY/ONE/FULL) SHALL be a typedef in the shared pipeline package, alongside the shared NOP instruction constant used as NOP_VAL for instruction-carrying stages.
REQ-030 SHALL be a single module; no sub-modules.

Verification (WIDTH=16, NOP_VAL=16'h0000)
REQ-031 Stream 16'h1001, 16'h1002, 16'h1003 with out_ready=1 -> out_data 1001/1002/1003 on consecutive cycles, one cycle after each accept; occupancy stays 1.
REQ-032 Accept 16'hA000, then 16'hA001 with out_ready=0 -> occupancy=2, in_ready=0 next cycle, out_data=A000; raise out_ready -> A000 then A001 delivered in order, in_ready=1 after first consume.
REQ-033 FULL with 16'hB000/16'hB001, assert flush with in_valid=1, in_data=16'hB002 -> next cycle occupancy=0, out_valid=0, out_data=0000; B002 never appears.
REQ-034 Drop rst_n asynchronously while occupancy=2 -> outputs reach reset values before next clk edge; post-reset 16'hC000 delivered after 1 cycle.
REQ-035 With PLR_ELASTIC_STALL_CNT_EN, hold out_valid=1, out_ready=0 for 5 cycles -> stall_cnt=5; preload near limit -> stall_cnt holds 16'hFFFF.
